// File: rtl/div_by_sub_if.sv
// div_by_sub_if: start/operand request and quotient/remainder/status result bundle of the repeated-subtraction divider
interface div_by_sub_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  modport master (output start, dividend, divisor,
                  input  quotient, remainder, busy, done, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output quotient, remainder, busy, done, div_by_zero);
endinterface

// File: rtl/div_by_sub.sv
// div_by_sub: unsigned divider by repeated subtraction; ports clk, rst_n (async low), bus (start/dividend/divisor in, quotient/remainder/busy/done/div_by_zero out)
module div_by_sub #(parameter int WIDTH = 16) (
  input logic       clk,
  input logic       rst_n,
  div_by_sub_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;
  state_t           state;
  logic [WIDTH-1:0] q, r, b;
  logic             busy, done, dbz;
  assign bus.quotient    = q;
  assign bus.remainder   = r;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = dbz;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      r     <= '0;
      b     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else
      case (state)
        IDLE, DONE:
          if (bus.start) begin
            r     <= bus.dividend;
            b     <= bus.divisor;
            q     <= '0;
            dbz   <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= CALC;
          end
        CALC:
          if (b == '0) begin
            dbz   <= 1'b1;
            q     <= '1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (r >= b) begin
            r <= r - b;
            q <= q + 1'b1;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_div_by_sub.sv
// tb_div_by_sub: directed and randomized checks of div_by_sub against an arithmetic reference model
module tb_div_by_sub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  div_by_sub_if #(.WIDTH(16)) bus ();
  div_by_sub #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output int lat);
    dz  = (b == 0);
    q   = dz ? 16'hFFFF : a / b;
    r   = dz ? a : a % b;
    lat = dz ? 1 : int'(a / b) + 1;
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b, input int n);
    logic [15:0] eq, er;
    logic        ed;
    int          el;
    model(a, b, eq, er, ed, el);
    chk({tag, " latency"}, 64'(n), 64'(el));
    chk({tag, " q/r/dz/busy/done"}, {bus.quotient, bus.remainder, bus.div_by_zero, bus.busy, bus.done},
        {eq, er, ed, 1'b0, 1'b1});
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    int n;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, " busy after accept"}, {bus.busy, bus.done}, 2'b10);
    bus.dividend = 16'($urandom);
    bus.divisor  = 16'($urandom);
    wait_done(n);
    check_result(tag, a, b, n);
  endtask

  initial begin
    logic [15:0] ha, hb, na, nb;
    int n;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}, 35'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", {bus.busy, bus.done}, 2'b00);

    do_op("17/5", 16'd17, 16'd5);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("17/5 hold", {bus.quotient, bus.remainder, bus.div_by_zero, bus.busy, bus.done},
          {16'd3, 16'd2, 1'b0, 1'b0, 1'b1});
    end
    do_op("4/7", 16'd4, 16'd7);
    do_op("20/4", 16'd20, 16'd4);
    do_op("0/9", 16'd0, 16'd9);
    do_op("123/0", 16'd123, 16'd0);
    do_op("9/3 after zero", 16'd9, 16'd3);

    bus.dividend = 16'd1000;
    bus.divisor  = 16'd1;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (300) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset mid-calc", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}, 35'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle after abort", {bus.quotient, bus.remainder, bus.busy, bus.done}, 34'd0);
    do_op("10/3 after abort", 16'd10, 16'd3);

    ha = 16'd9;
    hb = 16'd3;
    bus.dividend = ha;
    bus.divisor  = hb;
    bus.start    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("held start accept", {bus.busy, bus.done}, 2'b10);
      bus.dividend = 16'($urandom);
      bus.divisor  = 16'($urandom);
      wait_done(n);
      check_result("held start", ha, hb, n);
      na = 16'($urandom_range(0, 150));
      nb = 16'($urandom_range(0, 12));
      bus.dividend = na;
      bus.divisor  = nb;
      ha = na;
      hb = nb;
    end
    @(posedge clk); #1;
    chk("done pulse drops", {bus.busy, bus.done}, 2'b10);
    bus.start = 1'b0;
    wait_done(n);
    check_result("held start last", ha, hb, n);

    for (int k = 0; k < 25; k++) begin
      na = 16'($urandom);
      nb = (k % 7 == 0) ? 16'd0 : 16'($urandom_range(1, 16'hFFFF));
      if (nb != 0 && na / nb > 400) nb = 16'(na / 400 + 1);
      do_op("random", na, nb);
      repeat (k % 3) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
